// File: rtl/hybrid_input_loader.sv
// Byte-stream loader for the hybrid encryptor: collects a message and a key,
// pads the message, repeats the key to N characters and holds both until they are consumed.
//
// state  | meaning
// MSG    | accepting message bytes
// KEY    | accepting key bytes
// EXPAND | repeating a short key to N characters
// HOLD   | block complete, waiting for out_ready
module hybrid_input_loader #(
    parameter int         N        = 32,
    parameter logic [7:0] TERM     = 8'h0D,
    parameter logic [7:0] PAD_CHAR = 8'h20
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [7:0]     in_data,
    input  logic           in_valid,
    output logic           in_ready,
    output logic [8*N-1:0] message,
    output logic [8*N-1:0] key,
    output logic           out_valid,
    input  logic           out_ready
);
    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {S_MSG, S_KEY, S_EXPAND, S_HOLD} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, klen, src_idx;
    logic [7:0]    msg_q [N];
    logic [7:0]    key_q [N];
    logic [7:0]    exp_byte;
    logic          accept, is_term;

    assign accept  = in_valid && in_ready;
    assign is_term = (in_data == TERM);
    assign src_idx = cnt - klen;

    always_ff @(posedge clk) begin
        if (rst) state <= S_MSG;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_MSG:
                if (accept && (is_term || cnt == LAST)) state_nxt = S_KEY;
            S_KEY:
                if (accept) begin
                    if (is_term) begin
                        if (cnt != '0) state_nxt = S_EXPAND;
                    end else if (cnt == LAST) begin
                        state_nxt = S_HOLD;
                    end
                end
            S_EXPAND:
                if (cnt == LAST) state_nxt = S_HOLD;
            S_HOLD:
                if (out_ready) state_nxt = S_MSG;
            default: state_nxt = S_MSG;
        endcase
    end

    always_comb begin
        in_ready = 1'b0;
        if (state == S_MSG || state == S_KEY) in_ready = 1'b1;
    end

    // Key character one period back; the mux avoids indexing with a wider counter
    always_comb begin
        exp_byte = '0;
        for (int j = 0; j < N; j++)
            if (src_idx == CW'(j)) exp_byte = key_q[j];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            klen      <= '0;
            msg_q     <= '{default: '0};
            key_q     <= '{default: '0};
            out_valid <= 1'b0;
        end else begin
            out_valid <= (state_nxt == S_HOLD);
            case (state)
                S_MSG:
                    if (accept) begin
                        if (is_term) begin
                            for (int i = 0; i < N; i++)
                                if (CW'(i) >= cnt) msg_q[i] <= PAD_CHAR;
                            cnt <= '0;
                        end else begin
                            for (int i = 0; i < N; i++)
                                if (cnt == CW'(i)) msg_q[i] <= in_data;
                            cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
                        end
                    end
                S_KEY:
                    if (accept) begin
                        if (is_term) begin
                            if (cnt != '0) klen <= cnt;
                        end else begin
                            for (int i = 0; i < N; i++)
                                if (cnt == CW'(i)) key_q[i] <= in_data;
                            cnt <= cnt + CW'(1);
                        end
                    end
                S_EXPAND: begin
                    for (int i = 0; i < N; i++)
                        if (cnt == CW'(i)) key_q[i] <= exp_byte;
                    cnt <= cnt + CW'(1);
                end
                S_HOLD:
                    if (out_ready) begin
                        cnt  <= '0;
                        klen <= '0;
                    end
                default: ;
            endcase
        end
    end

    // Character 0 lands in the MSBs
    for (genvar g = 0; g < N; g++) begin : g_pack
        assign message[8*(N-1-g) +: 8] = msg_q[g];
        assign key[8*(N-1-g) +: 8]     = key_q[g];
    end
endmodule

// File: tb/tb_hybrid_input_loader.sv
// Directed bench for hybrid_input_loader with N=4; each task checks its own scenario.
module tb_hybrid_input_loader;
    localparam int N = 4;
    localparam logic [7:0] TERM = 8'h0D;

    logic            clk = 1'b0;
    logic            rst;
    logic [7:0]      in_data;
    logic            in_valid;
    logic            in_ready;
    logic [8*N-1:0]  message;
    logic [8*N-1:0]  key;
    logic            out_valid;
    logic            out_ready;

    int checks   = 0;
    int failures = 0;

    hybrid_input_loader #(.N(N), .TERM(8'h0D), .PAD_CHAR(8'h20)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .message(message), .key(key),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        in_data  = b;
        in_valid = 1'b1;
        while (!in_ready && n < 20) begin
            step();
            n++;
        end
        checks++;
        if (!in_ready) begin
            failures++;
            $display("FAIL send_byte_timeout in_ready=%0b required=1", in_ready);
        end
        step();
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int cycles);
        cycles = 0;
        while (!out_valid && cycles < 50) begin
            step();
            cycles++;
        end
    endtask

    task automatic consume();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || message !== 32'h0 || key !== 32'h0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset out_valid=%0b msg=%h key=%h in_ready=%0b required 0/0/0/1",
                     out_valid, message, key, in_ready);
        end
    endtask

    task automatic test_short_pad();
        int cyc;
        send_byte(8'h48); send_byte(8'h49); send_byte(TERM);
        send_byte(8'h4B); send_byte(8'h59); send_byte(TERM);
        wait_valid(cyc);
        checks++;
        if (cyc != 2) begin
            failures++;
            $display("FAIL short_pad_expand_cycles got=%0d required=2", cyc);
        end
        checks++;
        if (message !== 32'h48492020 || key !== 32'h4B594B59) begin
            failures++;
            $display("FAIL short_pad_data msg=%h key=%h required 48492020/4B594B59", message, key);
        end
        consume();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL short_pad_release out_valid=%0b in_ready=%0b required 0/1", out_valid, in_ready);
        end
    endtask

    task automatic load_full();
        send_byte(8'h41); send_byte(8'h42); send_byte(8'h43); send_byte(8'h44);
        send_byte(8'h57); send_byte(8'h58); send_byte(8'h59); send_byte(8'h5A);
    endtask

    task automatic test_full();
        checks++;
        load_full();
        if (out_valid !== 1'b1 || message !== 32'h41424344 || key !== 32'h5758595A) begin
            failures++;
            $display("FAIL full_block out_valid=%0b msg=%h key=%h required 1/41424344/5758595A",
                     out_valid, message, key);
        end
        consume();
    endtask

    task automatic test_empty_key_term();
        int cyc;
        send_byte(8'h51); send_byte(TERM);
        send_byte(TERM);
        send_byte(8'h4B); send_byte(8'h45); send_byte(8'h59); send_byte(TERM);
        wait_valid(cyc);
        checks++;
        if (cyc != 1) begin
            failures++;
            $display("FAIL empty_key_term_cycles got=%0d required=1", cyc);
        end
        checks++;
        if (message !== 32'h51202020 || key !== 32'h4B45594B) begin
            failures++;
            $display("FAIL empty_key_term_data msg=%h key=%h required 51202020/4B45594B", message, key);
        end
        consume();
    endtask

    task automatic test_hold_backpressure();
        int bad;
        bad = 0;
        load_full();
        in_data  = 8'h41;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (in_ready !== 1'b0 || out_valid !== 1'b1 ||
                message !== 32'h41424344 || key !== 32'h5758595A) bad++;
            step();
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL hold_stable bad_cycles=%0d required=0", bad);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        in_valid  = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || message !== 32'h41424344) begin
            failures++;
            $display("FAIL hold_release in_ready=%0b out_valid=%0b msg=%h required 1/0/41424344",
                     in_ready, out_valid, message);
        end
    endtask

    task automatic test_mid_reset();
        send_byte(8'h41); send_byte(8'h42); send_byte(8'h43); send_byte(8'h44);
        send_byte(8'h57); send_byte(8'h58);
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || message !== 32'h0 || key !== 32'h0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL mid_reset out_valid=%0b msg=%h key=%h in_ready=%0b required 0/0/0/1",
                     out_valid, message, key, in_ready);
        end
        load_full();
        checks++;
        if (out_valid !== 1'b1 || message !== 32'h41424344 || key !== 32'h5758595A) begin
            failures++;
            $display("FAIL mid_reset_reload out_valid=%0b msg=%h key=%h required 1/41424344/5758595A",
                     out_valid, message, key);
        end
        consume();
    endtask

    task automatic test_empty_msg();
        int cyc;
        send_byte(TERM); send_byte(TERM); send_byte(8'h5A); send_byte(TERM);
        wait_valid(cyc);
        checks++;
        if (cyc != 3) begin
            failures++;
            $display("FAIL empty_msg_cycles got=%0d required=3", cyc);
        end
        checks++;
        if (message !== 32'h20202020 || key !== 32'h5A5A5A5A) begin
            failures++;
            $display("FAIL empty_msg_data msg=%h key=%h required 20202020/5A5A5A5A", message, key);
        end
        consume();
    endtask

    initial begin
        rst       = 1'b1;
        in_data   = 8'h00;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        test_reset();
        test_short_pad();
        test_full();
        test_empty_key_term();
        test_hold_backpressure();
        test_mid_reset();
        test_empty_msg();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
